// File: rtl/dec38_display_if.sv
// dec38_display_if: switch-side inputs and display-side outputs of the
// 3-to-8 display decoder, grouped into one bundle.
//   master : drives sw_code/sw_valid/en and observes the display outputs
//   slave  : the decoder itself
//   sw_code[2:0]    encoded index 0..7
//   sw_valid        index is meaningful (encoder indicator)
//   en              output enable
//   led_onehot[7:0] one-hot decode of the committed index
//   hex0[7:0]       active-low 7-seg, bit0=a .. bit6=g, bit7=dp
//   led_indi        committed en & committed valid
//   upd_pulse       one-cycle pulse on each commit
//   fsm_state[1:0]  IDLE/SETTLE/COMMIT view, for coverage only
interface dec38_display_if;
  logic [2:0] sw_code;
  logic       sw_valid;
  logic       en;
  logic [7:0] led_onehot;
  logic [7:0] hex0;
  logic       led_indi;
  logic       upd_pulse;
  logic [1:0] fsm_state;

  modport master (output sw_code, sw_valid, en,
                  input  led_onehot, hex0, led_indi, upd_pulse, fsm_state);
  modport slave  (input  sw_code, sw_valid, en,
                  output led_onehot, hex0, led_indi, upd_pulse, fsm_state);
endinterface

// File: rtl/dec38_display.sv
// dec38_display: debounces the 5-bit switch word {en, valid, code}, commits
// it once it has been stable long enough and drives registered LED/7-seg
// outputs from the committed word.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : dec38_display_if.slave (switch inputs, display outputs)
module dec38_display #(
  parameter int STABLE_CYCLES = 4,   // 1..255
  parameter int CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst,
  dec38_display_if.slave  bus
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(STABLE_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [4:0]       w_s;
  logic [4:0]       r_s_q;
  logic [4:0]       r_cand;
  logic [4:0]       r_com;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_led;
  logic [7:0]       r_hex;
  logic             r_indi;
  logic             r_upd;
  logic             w_commit;
  logic             w_act;
  logic [1:0]       w_state;

  function automatic logic [7:0] seg7(input logic [2:0] c);
    logic [7:0] s;
    case (c)
      3'd0:    s = 8'hC0;
      3'd1:    s = 8'hF9;
      3'd2:    s = 8'hA4;
      3'd3:    s = 8'hB0;
      3'd4:    s = 8'h99;
      3'd5:    s = 8'h92;
      3'd6:    s = 8'h82;
      default: s = 8'hF8;
    endcase
    return s;
  endfunction

  assign w_s = {bus.en, bus.sw_valid, bus.sw_code};

  // Candidate has been seen SAT times in a row, is still present, and is new.
  assign w_commit = (r_cnt == SAT) && (r_s_q == r_cand) && (r_cand != r_com);

  // Outputs are loaded from the candidate, which becomes com on this edge.
  assign w_act = r_cand[4] & r_cand[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_q  <= '0;
      r_cand <= '0;
      r_com  <= '0;
      r_cnt  <= SAT;
      r_led  <= 8'h00;
      r_hex  <= 8'hFF;
      r_indi <= 1'b0;
      r_upd  <= 1'b0;
    end else begin
      r_s_q <= w_s;
      if (r_s_q != r_cand) begin
        r_cand <= r_s_q;
        r_cnt  <= CNT_W'(1);
      end else if (r_cnt < SAT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_upd <= w_commit;
      if (w_commit) begin
        r_com  <= r_cand;
        r_led  <= w_act ? (8'h01 << r_cand[2:0]) : 8'h00;
        r_hex  <= w_act ? seg7(r_cand[2:0]) : 8'hFF;
        r_indi <= w_act;
      end
    end
  end

  // A saturated counter with a fresh sample pending still counts as settling.
  always_comb begin
    w_state = ST_IDLE;
    if (w_commit)
      w_state = ST_COMMIT;
    else if ((r_cnt < SAT) || (r_s_q != r_cand))
      w_state = ST_SETTLE;
  end

  assign bus.led_onehot = r_led;
  assign bus.hex0       = r_hex;
  assign bus.led_indi   = r_indi;
  assign bus.upd_pulse  = r_upd;
  assign bus.fsm_state  = w_state;

endmodule

// File: tb/tb_dec38_display.sv
// tb_dec38_display: directed stimulus pushes expected commits (cycle, LEDs,
// 7-seg, indicator) into a queue; a negedge monitor pops on every upd_pulse
// and otherwise checks that the outputs hold their last committed value.
module tb_dec38_display;

  typedef struct {
    int         at;
    logic [7:0] led;
    logic [7:0] hex;
    logic       indi;
  } exp_t;

  localparam int LAT = 6;          // change before edge 1 -> commit at edge 6
  localparam int MIN_HOLD = 5;     // edges a word must be held to commit

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_at_edge = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t q[$];
  exp_t cur = '{at: 0, led: 8'h00, hex: 8'hFF, indi: 1'b0};

  logic [4:0] cur_w = 5'b0;
  logic [4:0] com_m = 5'b0;
  int         chg = 0;
  bit         pushed = 1'b0;

  logic [7:0] seg_tbl [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  dec38_display_if bus();

  dec38_display #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_at_edge <= rst;
    cyc         <= cyc + 1;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (rst_at_edge) begin
        n_chk++;
        if (bus.led_onehot !== 8'h00 || bus.hex0 !== 8'hFF ||
            bus.led_indi !== 1'b0 || bus.upd_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_state cyc=%0d: got led=%h hex=%h indi=%b upd=%b, exp 00 FF 0 0",
                   cyc, bus.led_onehot, bus.hex0, bus.led_indi, bus.upd_pulse);
        end
        cur = '{at: 0, led: 8'h00, hex: 8'hFF, indi: 1'b0};
      end else if (bus.upd_pulse === 1'b1) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse cyc=%0d: got upd_pulse=1, exp 0", cyc);
        end else begin
          e = q.pop_front();
          if (cyc != e.at || bus.led_onehot !== e.led || bus.hex0 !== e.hex ||
              bus.led_indi !== e.indi) begin
            n_fail++;
            $display("FAIL commit cyc=%0d: got led=%h hex=%h indi=%b, exp cyc=%0d led=%h hex=%h indi=%b",
                     cyc, bus.led_onehot, bus.hex0, bus.led_indi, e.at, e.led, e.hex, e.indi);
          end
          cur = e;
        end
      end else begin
        if (q.size() != 0 && q[0].at <= cyc) begin
          n_chk++;
          n_fail++;
          e = q.pop_front();
          $display("FAIL missed_pulse cyc=%0d: got upd_pulse=%b, exp 1 (led=%h hex=%h)",
                   cyc, bus.upd_pulse, e.led, e.hex);
        end
        n_chk++;
        if (bus.led_onehot !== cur.led || bus.hex0 !== cur.hex || bus.led_indi !== cur.indi) begin
          n_fail++;
          $display("FAIL hold cyc=%0d: got led=%h hex=%h indi=%b, exp led=%h hex=%h indi=%b",
                   cyc, bus.led_onehot, bus.hex0, bus.led_indi, cur.led, cur.hex, cur.indi);
        end
      end
      n_chk++;
      if ($countones(bus.led_onehot) > 1 || bus.hex0[7] !== 1'b1) begin
        n_fail++;
        $display("FAIL invariant cyc=%0d: got led=%h hex=%h, exp <=1 hot and dp=1",
                 cyc, bus.led_onehot, bus.hex0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] w);
    {bus.en, bus.sw_valid, bus.sw_code} = w;
  endtask

  // Drive word w for 'hold' edges; queue the expected commit if it will occur.
  task automatic apply(input logic [4:0] w, input int hold,
                       input logic [7:0] eled, input logic [7:0] ehex, input logic eindi);
    exp_t e;
    if (w !== cur_w) begin
      cur_w  = w;
      chg    = cyc;
      pushed = 1'b0;
    end
    drive(w);
    if (!pushed && (cyc + hold - chg >= MIN_HOLD) && (w != com_m)) begin
      e = '{at: chg + LAT, led: eled, hex: ehex, indi: eindi};
      q.push_back(e);
      com_m  = w;
      pushed = 1'b1;
    end
    step(hold);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    rst    = 1'b0;
    com_m  = 5'b0;
    chg    = cyc;
    pushed = 1'b0;
  endtask

  initial begin
    logic [7:0] sw;
    logic [2:0] code;
    logic       vld;
    logic [7:0] eled;

    // 1. reset with arbitrary inputs
    cur_w = 5'b10011;
    drive(cur_w);
    do_reset(2);

    // 2. basic decode
    apply(5'b11_101, 10, 8'h20, 8'h92, 1'b1);
    apply(5'b11_000, 10, 8'h01, 8'hC0, 1'b1);

    // 3. bounce 3<->4 every 2 cycles, then hold 4
    for (int i = 0; i < 5; i++) begin
      apply(5'b11_011, 2, 8'h08, 8'hB0, 1'b1);
      apply(5'b11_100, 2, 8'h10, 8'h99, 1'b1);
    end
    apply(5'b11_100, 8, 8'h10, 8'h99, 1'b1);

    // 4. enable / valid gating, then same word again after a glitch
    apply(5'b01_111, 10, 8'h00, 8'hFF, 1'b0);
    apply(5'b10_111, 10, 8'h00, 8'hFF, 1'b0);
    apply(5'b11_010, 2, 8'h04, 8'hA4, 1'b1);
    apply(5'b10_111, 10, 8'h00, 8'hFF, 1'b0);

    // 5. reset at edge 3 of a settle, then the held word commits normally
    apply(5'b11_110, 2, 8'h40, 8'h82, 1'b1);
    do_reset(1);
    apply(5'b11_110, 10, 8'h40, 8'h82, 1'b1);

    // 6. round trip through a priority-encoder model
    for (int i = 0; i < 256; i++) begin
      sw   = 8'(i);
      code = 3'd0;
      eled = 8'h00;
      for (int b = 0; b < 8; b++)
        if (sw[b]) begin
          code = 3'(b);
          eled = 8'h01 << b;
        end
      vld = (sw != 8'h00);
      apply({1'b1, vld, code}, 6, eled, vld ? seg_tbl[code] : 8'hFF, vld);
    end

    for (int i = 0; i < 40 && q.size() != 0; i++) step(1);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending commits, exp 0", q.size());
    end
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dec38_display.md
Name: dec38_display

Overview:
- Decoder end of the switch-encoder path: takes a 3-bit index plus valid and enable from board switches.
- Filters switch bounce, commits the filtered value and drives three outputs: an 8-bit one-hot LED bus, an active-low 7-segment digit and a valid indicator.
- Sits on the NVBoard top level beside the priority encoder, so an encoded index can be round-tripped back to one-hot.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before commit; legal range 1..255.
- CNT_W, 8: width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- sw_code  input  3  encoded index 0..7.
- sw_valid  input  1  index is meaningful; encoder indicator.
- en  input  1  output enable.
- led_onehot  output  8  registered one-hot decode of the committed index.
- hex0  output  8  active-low segments; bit0=a … bit6=g, bit7=dp (always 1).
- led_indi  output  1  committed en AND committed valid.
- upd_pulse  output  1  one-cycle pulse on each commit.

Behaviour:
- Sample word S = {en, sw_valid, sw_code}, 5 bits; every field is compared.
- s_q captures S on every edge.
- Registers: cand (5b), cnt (CNT_W), com (5b, committed).
- Reset (rst=1 at an edge):
  - s_q, cand and com = 0.
  - cnt = STABLE_CYCLES (saturated).
  - led_onehot = 8'h00, hex0 = 8'hFF, led_indi = 0, upd_pulse = 0.
  - Reset mid-settle discards the pending candidate.
- Per edge, rst=0:
  - If s_q != cand: cand <= s_q, cnt <= 1.
  - Else if cnt < STABLE_CYCLES: cnt <= cnt+1.
  - cnt saturates at STABLE_CYCLES and never wraps.
- Commit:
  - At an edge where cnt == STABLE_CYCLES, s_q == cand and cand != com: com <= cand and upd_pulse <= 1.
  - upd_pulse is 0 on every other edge.
  - No commit when cand == com, so there is no pulse on a repeat value.
- FSM, derived and exposed for coverage only:
  - IDLE: cnt saturated and cand == com.
  - SETTLE: cnt < STABLE_CYCLES.
  - COMMIT: single cycle in which the commit condition holds.
  - Transitions: IDLE→SETTLE on sample change; SETTLE→SETTLE on further change (count restarts); SETTLE→COMMIT when cnt reaches STABLE_CYCLES with a value differing from com; SETTLE→IDLE when it reaches STABLE_CYCLES with a value equal to com; COMMIT→IDLE.
- Latency:
  - If S changes before edge 1 and then holds, outputs and upd_pulse change at edge STABLE_CYCLES+2. With the default this is edge 6.
  - STABLE_CYCLES=1 gives edge 3.
- Glitches: any change of S shorter than STABLE_CYCLES consecutive samples never reaches the outputs.
- Outputs are registered and updated at the commit edge from the new com value:
  - act = com.en & com.valid.
  - led_onehot = act ? (8'h01 << com.code) : 8'h00.
  - led_indi = act.
  - hex0 = act ? SEG(com.code) : 8'hFF.
- SEG table, active low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8.
- Invariant: led_onehot is always zero-hot or one-hot.

Test Plan:
1. Reset: rst=1 for 2 cycles with arbitrary inputs → led_onehot=00, hex0=FF, led_indi=0, upd_pulse=0.
2. Basic decode: after reset apply en=1, valid=1, code=5 and hold → at edge 6 led_onehot=20, hex0=92, led_indi=1, upd_pulse=1 for exactly one cycle; then code=0 held → led_onehot=01, hex0=C0.
3. Bounce rejection: toggle code 3↔4 every 2 cycles for 20 cycles → no output change, no upd_pulse; then hold 4 → led_onehot=10 at the 6th edge after the last change.
4. Enable and valid gating:
   - en=0 with code=7, valid=1 → led_onehot=00, hex0=FF, led_indi=0, one upd_pulse.
   - en=1, valid=0 → same outputs, one upd_pulse.
   - Re-applying the same word → no pulse.
5. Reset mid-settle: change to code=6 and assert rst at edge 3 → outputs stay at reset values and no pulse; the later stable code=6 commits at the normal latency.
6. Round trip with the encoder: sweep sw over all 256 values with en=1 and feed encoder output plus indicator to this block → led_onehot equals the highest set bit of sw (00 when sw=00), and hex0 matches the SEG entry.
